// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames with optional parity and 1/2 stop bits.
// Word pushed into an idle block starts its start bit one edge later; writes while full are dropped.

module uart_tx_cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  // Full blocks a push even when a pop happens on the same edge.
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module uart_tx_cfg #(
  parameter int CLOCK_SPEED = 25_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Active,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Done
);
  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLOCK_SPEED/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;

  logic                 pop;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 clk_last;
  logic                 frame_end;

  uart_tx_cfg_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .push_i     (i_TX_DV),
    .push_dat_i (i_TX_Byte),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (o_FIFO_Count)
  );

  assign clk_last  = (clk_cnt_q == LAST_CLK);
  assign frame_end = (state_q == S_STOP) && clk_last && (bit_idx_q == LAST_STOP);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    serial_d  = serial_q;
    pop       = 1'b0;

    if (state_q != S_IDLE) clk_cnt_d = clk_last ? '0 : clk_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: serial_d = 1'b1;
      S_START: begin
        if (clk_last) begin
          state_d   = S_DATA;
          serial_d  = shift_q[0];
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (clk_last) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            // Shift so the next data bit always sits at bit 1 of the current word.
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (clk_last) begin
          state_d  = S_STOP;
          serial_d = 1'b1;
        end
      end
      S_STOP: begin
        if (clk_last) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Loading from idle or from the last stop cycle keeps frames back-to-back.
    if ((state_q == S_IDLE || frame_end) && !fifo_empty) begin
      pop       = 1'b1;
      shift_d   = fifo_dat;
      par_d     = (^fifo_dat) ^ (PARITY == 2);
      state_d   = S_START;
      serial_d  = 1'b0;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
    end
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = (state_q != S_IDLE);
  assign o_TX_Done   = frame_end;
  assign o_TX_Ready  = !fifo_full;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five configurations, frames predicted into a scoreboard and checked bit-by-bit per clock.
module tb_uart_tx_cfg;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] dv = '0;
  logic [8:0] tx_byte = '0;
  wire  [4:0] ser, act, done, rdy;
  wire  [2:0] cnt [5];
  logic [2:0] sel = '0;
  logic       mser, mact, mdone;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign mser  = ser[sel];
  assign mact  = act[sel];
  assign mdone = done[sel];

  int db_c [5] = '{8, 7, 7, 8, 9};
  int par_c[5] = '{0, 1, 2, 0, 0};
  int ns_c [5] = '{1, 1, 1, 2, 1};

  uart_tx_cfg #(.CLOCK_SPEED(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
  u_8n1 (.i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[0]), .i_TX_Byte(tx_byte[7:0]), .o_TX_Ready(rdy[0]),
         .o_FIFO_Count(cnt[0]), .o_TX_Active(act[0]), .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));
  uart_tx_cfg #(.CLOCK_SPEED(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
  u_7e1 (.i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[1]), .i_TX_Byte(tx_byte[6:0]), .o_TX_Ready(rdy[1]),
         .o_FIFO_Count(cnt[1]), .o_TX_Active(act[1]), .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));
  uart_tx_cfg #(.CLOCK_SPEED(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
  u_7o1 (.i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[2]), .i_TX_Byte(tx_byte[6:0]), .o_TX_Ready(rdy[2]),
         .o_FIFO_Count(cnt[2]), .o_TX_Active(act[2]), .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));
  uart_tx_cfg #(.CLOCK_SPEED(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
  u_8n2 (.i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[3]), .i_TX_Byte(tx_byte[7:0]), .o_TX_Ready(rdy[3]),
         .o_FIFO_Count(cnt[3]), .o_TX_Active(act[3]), .o_TX_Serial(ser[3]), .o_TX_Done(done[3]));
  uart_tx_cfg #(.CLOCK_SPEED(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
  u_9n1 (.i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[4]), .i_TX_Byte(tx_byte[8:0]), .o_TX_Ready(rdy[4]),
         .o_FIFO_Count(cnt[4]), .o_TX_Active(act[4]), .o_TX_Serial(ser[4]), .o_TX_Done(done[4]));

  typedef struct {
    int          nbits;
    logic [15:0] bits;
  } frame_t;

  frame_t sb[$];
  int     starts[$];
  int     checks = 0;
  int     errors = 0;
  int     aborts = 0;
  bit     in_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line levels of one whole frame, LSB-first: start, data, optional parity, stop bits.
  function automatic frame_t make_frame(input logic [8:0] w, input int db, input int par, input int nstop);
    frame_t f;
    logic   p;
    int     n;
    f.bits = '0;
    p = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin
      f.bits[n] = w[i];
      p = p ^ w[i];
      n++;
    end
    if (par == 1) begin f.bits[n] = p;  n++; end
    if (par == 2) begin f.bits[n] = ~p; n++; end
    for (int i = 0; i < nstop; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    return f;
  endfunction

  task automatic put(input int inst, input logic [8:0] w, input bit accept);
    @(negedge clk);
    dv = '0;
    dv[inst] = 1'b1;
    tx_byte = w;
    if (accept) sb.push_back(make_frame(w, db_c[inst], par_c[inst], ns_c[inst]));
  endtask

  task automatic release_dv;
    @(negedge clk);
    dv = '0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_frame && mact === 1'b0) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_gap(input string tag, input int idx, input int exp);
    if (starts.size() > idx) chk(tag, starts[idx] - starts[idx-1], exp);
    else chk({tag, "_seen"}, starts.size(), idx + 1);
  endtask

  // Monitor: every clock of a frame is compared against the predicted line level.
  initial begin : monitor
    frame_t      e;
    logic [15:0] obs;
    int          bad_bit, bad_done, bad_act;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mser === 1'b0) begin
        in_frame = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_frame", sb.size(), 1);
          for (int i = 0; i < 200 && mact === 1'b1; i++) @(negedge clk);
        end else begin
          e = sb.pop_front();
          starts.push_back(cyc);
          obs = '0; bad_bit = 0; bad_done = 0; bad_act = 0; aborted = 1'b0;
          for (int k = 0; k < e.nbits * CPB && !aborted; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else begin
              if (k % CPB == CPB / 2) obs[k / CPB] = mser;
              if (mser !== e.bits[k / CPB]) bad_bit++;
              if (mdone !== (k == e.nbits * CPB - 1)) bad_done++;
              if (mact !== 1'b1) bad_act++;
            end
          end
          if (aborted) aborts++;
          else begin
            chk("frame_bits", {16'd0, obs}, {16'd0, e.bits});
            chk("bit_hold", bad_bit, 0);
            chk("done_pulse", bad_done, 0);
            chk("active_span", bad_act, 0);
          end
        end
        in_frame = 1'b0;
      end else begin
        chk("idle_done", {31'd0, mdone}, 32'd0);
        chk("idle_active", {31'd0, mact}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    int a0;
    int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_serial", {31'd0, ser[i]}, 32'd1);
      chk("rst_active", {31'd0, act[i]}, 32'd0);
      chk("rst_done",   {31'd0, done[i]}, 32'd0);
      chk("rst_count",  {29'd0, cnt[i]}, 32'd0);
      chk("rst_ready",  {31'd0, rdy[i]}, 32'd1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 single word 0xA5 with latency probe
    sel = 3'd0;
    starts.delete();
    put(0, 9'h0A5, 1'b1);
    t0 = cyc;
    release_dv();
    chk("t1_count_after_push", {29'd0, cnt[0]}, 32'd1);
    chk("t1_active_before_start", {31'd0, act[0]}, 32'd0);
    @(negedge clk);
    chk("t1_count_after_pop", {29'd0, cnt[0]}, 32'd0);
    chk("t1_serial_start", {31'd0, ser[0]}, 32'd0);
    wait_idle("t1_idle", 300);
    if (starts.size() > 0) chk("t1_start_latency", starts[0], t0 + 2);
    else chk("t1_start_seen", starts.size(), 1);

    // 7E1 and 7O1 with 0x35
    sel = 3'd1;
    put(1, 9'h035, 1'b1);
    release_dv();
    wait_idle("t2_even_idle", 300);
    sel = 3'd2;
    put(2, 9'h035, 1'b1);
    release_dv();
    wait_idle("t2_odd_idle", 300);

    // 8N2 back-to-back burst
    sel = 3'd3;
    starts.delete();
    put(3, 9'h000, 1'b1);
    put(3, 9'h0FF, 1'b1);
    put(3, 9'h055, 1'b1);
    release_dv();
    wait_idle("t3_idle", 600);
    chk_gap("t3_gap_1", 1, 110);
    chk_gap("t3_gap_2", 2, 110);

    // FIFO fill: six writes, sixth dropped
    sel = 3'd0;
    for (int w = 1; w <= 6; w++) begin
      put(0, 9'(w), w <= 5);
      if (w >= 2) begin
        chk("t4_count", {29'd0, cnt[0]}, exp_cnt[w-2]);
        chk("t4_ready", {31'd0, rdy[0]}, {31'd0, exp_cnt[w-2] < 4});
      end
    end
    release_dv();
    chk("t4_count_peak", {29'd0, cnt[0]}, exp_cnt[5]);
    chk("t4_ready_full", {31'd0, rdy[0]}, 32'd0);
    wait_idle("t4_idle", 800);

    // Reset in mid-frame with two words queued
    put(0, 9'h0C3, 1'b1);
    put(0, 9'h011, 1'b1);
    put(0, 9'h022, 1'b1);
    release_dv();
    repeat (35) @(negedge clk);
    chk("t5_count_queued", {29'd0, cnt[0]}, 32'd2);
    chk("t5_active_pre", {31'd0, act[0]}, 32'd1);
    a0 = aborts;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_serial", {31'd0, ser[0]}, 32'd1);
    chk("t5_rst_active", {31'd0, act[0]}, 32'd0);
    chk("t5_rst_count",  {29'd0, cnt[0]}, 32'd0);
    chk("t5_rst_ready",  {31'd0, rdy[0]}, 32'd1);
    chk("t5_rst_done",   {31'd0, done[0]}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_aborted", aborts, a0 + 1);
    put(0, 9'h03C, 1'b1);
    release_dv();
    wait_idle("t5_idle", 300);
    repeat (30) @(negedge clk);

    // 9N1 words with bit 8 set
    sel = 3'd4;
    starts.delete();
    put(4, 9'h1FF, 1'b1);
    put(4, 9'h100, 1'b1);
    release_dv();
    wait_idle("t6_idle", 400);
    chk_gap("t6_gap", 1, 110);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
